// File: rtl/id_scan_ctrl.sv
// Streaming letter-then-digit identifier scanner with a one-entry record slot.
// Build option: define ID_SCAN_UNDERSCORE_EN to class '_' (0x5F) as a letter.
module id_scan_ctrl #(
   parameter int unsigned IDX_W = 16,
   parameter int unsigned LEN_W = 8,
   localparam int unsigned CHAR_W = 8,
   localparam int unsigned MATCH_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid_i,
   input  logic [CHAR_W-1:0]  in_char_i,
   input  logic               in_last_i,
   output logic               in_ready_o,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [IDX_W-1:0]   out_start_o,
   output logic [LEN_W-1:0]   out_len_o,
   output logic [MATCH_W-1:0] match_cnt_o,
   output logic               busy_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ALPHA = 2'd1,
      S_DIGIT = 2'd2
   } state_e;

   state_e              state_q, state_d, scan_nxt;
   logic                accept;
   logic                is_digit, is_alpha, is_other;
   logic                emit;
   logic [IDX_W-1:0]    pos_q, pos_d;
   logic [IDX_W-1:0]    seg_start_q, seg_start_d;
   logic [LEN_W-1:0]    seg_len_q, seg_len_d, seg_len_inc;
   logic                out_valid_q, out_valid_d;
   logic [IDX_W-1:0]    out_start_q, out_start_d;
   logic [LEN_W-1:0]    out_len_q, out_len_d;
   logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;

   assign in_ready_o  = !out_valid_q || out_ready_i;
   assign accept      = in_valid_i && in_ready_o;
   assign busy_o      = (state_q != S_IDLE) || out_valid_q;
   assign out_valid_o = out_valid_q;
   assign out_start_o = out_start_q;
   assign out_len_o   = out_len_q;
   assign match_cnt_o = match_cnt_q;

   // Character classification
   always_comb begin
      is_digit = (in_char_i >= 8'h30) && (in_char_i <= 8'h39);
      is_alpha = ((in_char_i >= 8'h41) && (in_char_i <= 8'h5A)) ||
                 ((in_char_i >= 8'h61) && (in_char_i <= 8'h7A));
`ifdef ID_SCAN_UNDERSCORE_EN
      is_alpha = is_alpha || (in_char_i == 8'h5F);
`else
      is_alpha = is_alpha;
`endif
      is_other = !is_digit && !is_alpha;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // scan_nxt ignores in_last so the final-digit emission can still see it
   always_comb begin
      scan_nxt = state_q;
      state_d  = state_q;
      case (state_q)
         S_IDLE:           scan_nxt = is_alpha ? S_ALPHA : S_IDLE;
         S_ALPHA, S_DIGIT: scan_nxt = is_digit ? S_DIGIT :
                                      (is_alpha ? S_ALPHA : S_IDLE);
         default:          scan_nxt = S_IDLE;
      endcase
      if (accept) state_d = in_last_i ? S_IDLE : scan_nxt;
   end

   always_comb begin
      pos_d       = pos_q;
      seg_start_d = seg_start_q;
      seg_len_d   = seg_len_q;
      out_valid_d = out_valid_q;
      out_start_d = out_start_q;
      out_len_d   = out_len_q;
      match_cnt_d = match_cnt_q;
      emit        = 1'b0;
      seg_len_inc = (&seg_len_q) ? seg_len_q : seg_len_q + LEN_W'(1);

      if (accept) begin
         pos_d = in_last_i ? '0 : pos_q + IDX_W'(1);
         if (state_q == S_IDLE && is_alpha) begin
            seg_start_d = pos_q;
            seg_len_d   = LEN_W'(1);
         end else if (state_q != S_IDLE && !is_other) begin
            seg_len_d = seg_len_inc;
         end
         // Terminator is excluded; a final digit is included
         if (state_q == S_DIGIT && is_other) begin
            emit        = 1'b1;
            out_start_d = seg_start_q;
            out_len_d   = seg_len_q;
         end else if (in_last_i && scan_nxt == S_DIGIT) begin
            emit        = 1'b1;
            out_start_d = seg_start_q;
            out_len_d   = seg_len_inc;
         end
      end

      if (emit) begin
         out_valid_d = 1'b1;
         match_cnt_d = match_cnt_q + MATCH_W'(1);
      end else if (out_valid_q && out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pos_q       <= '0;
         seg_start_q <= '0;
         seg_len_q   <= '0;
         out_valid_q <= 1'b0;
         out_start_q <= '0;
         out_len_q   <= '0;
         match_cnt_q <= '0;
      end else begin
         pos_q       <= pos_d;
         seg_start_q <= seg_start_d;
         seg_len_q   <= seg_len_d;
         out_valid_q <= out_valid_d;
         out_start_q <= out_start_d;
         out_len_q   <= out_len_d;
         match_cnt_q <= match_cnt_d;
      end
   end

endmodule

// File: tb/tb_id_scan_ctrl.sv
// Self-checking bench for id_scan_ctrl: directed streams plus random traffic
// scored against a stream-buffer reference model.
module tb_id_scan_ctrl;

   localparam int unsigned IDX_W   = 16;
   localparam int unsigned LEN_W   = 4;
   localparam int          LEN_MAX = 15;
`ifdef ID_SCAN_UNDERSCORE_EN
   localparam bit US_EN = 1'b1;
`else
   localparam bit US_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid_i;
   logic [7:0]       in_char_i;
   logic             in_last_i;
   logic             in_ready_o;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [IDX_W-1:0] out_start_o;
   logic [LEN_W-1:0] out_len_o;
   logic [15:0]      match_cnt_o;
   logic             busy_o;

   always #5 clk = ~clk;

   id_scan_ctrl #(.IDX_W(IDX_W), .LEN_W(LEN_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid_i),
      .in_char_i   (in_char_i),
      .in_last_i   (in_last_i),
      .in_ready_o  (in_ready_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_start_o (out_start_o),
      .out_len_o   (out_len_o),
      .match_cnt_o (match_cnt_o),
      .busy_o      (busy_o)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: characters of the current stream, plus the record slot
   logic [7:0] sbuf[$];
   bit         m_valid;
   int         m_start;
   int         m_len;
   int         m_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_dig(input logic [7:0] c);
      return (c >= 8'h30) && (c <= 8'h39);
   endfunction

   function automatic bit is_alp(input logic [7:0] c);
      return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A)) ||
             (US_EN && c == 8'h5F);
   endfunction

   function automatic bit is_aln(input logic [7:0] c);
      return is_dig(c) || is_alp(c);
   endfunction

   // Index of the first letter in the alphanumeric run ending at e, or -1
   function automatic int first_alpha(input int e);
      int s;
      if (e < 0) return -1;
      if (!is_aln(sbuf[e])) return -1;
      s = e;
      while (s > 0 && is_aln(sbuf[s-1])) s--;
      for (int i = s; i <= e; i++) if (is_alp(sbuf[i])) return i;
      return -1;
   endfunction

   function automatic bit m_busy();
      return m_valid || (first_alpha(sbuf.size() - 1) >= 0);
   endfunction

   task automatic cycle(input bit v, input logic [7:0] c, input bit l, input bit ordy,
                        input bit rn, output bit acc);
      bit exp_rdy;
      bit drain;
      bit has;
      int e;
      int fa;
      in_valid_i  = v;
      in_char_i   = c;
      in_last_i   = l;
      out_ready_i = ordy;
      rst_n       = rn;
      #1;
      exp_rdy = !m_valid || ordy;
      chk("in_ready", in_ready_o, exp_rdy);
      chk("busy", busy_o, m_busy());
      acc   = rn && v && exp_rdy;
      drain = m_valid && ordy;
      has   = 1'b0;
      if (!rn) begin
         sbuf.delete();
         m_valid = 1'b0;
         m_start = 0;
         m_len   = 0;
         m_cnt   = 0;
      end else begin
         if (acc) begin
            sbuf.push_back(c);
            e = -1;
            if (!is_aln(c))           e = sbuf.size() - 2;
            else if (l && is_dig(c))  e = sbuf.size() - 1;
            if (e >= 0) begin
               if (is_dig(sbuf[e])) begin
                  fa = first_alpha(e);
                  if (fa >= 0) begin
                     has     = 1'b1;
                     m_start = fa % 65536;
                     m_len   = (e - fa + 1 > LEN_MAX) ? LEN_MAX : e - fa + 1;
                  end
               end
            end
            if (l) sbuf.delete();
         end
         if (has) begin
            m_valid = 1'b1;
            m_cnt   = (m_cnt + 1) % 65536;
         end else if (drain) begin
            m_valid = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      chk("out_valid", out_valid_o, m_valid);
      chk("match_cnt", match_cnt_o, m_cnt);
      if (m_valid || !rn) begin
         chk("out_start", out_start_o, m_start);
         chk("out_len", out_len_o, m_len);
      end
   endtask

   task automatic send_char(input logic [7:0] c, input bit l);
      bit acc;
      acc = 1'b0;
      for (int k = 0; k < 40 && !acc; k++) cycle(1'b1, c, l, 1'b1, 1'b1, acc);
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_str(input string s, input bit last_on_end);
      for (int i = 0; i < s.len(); i++) send_char(s[i], last_on_end && (i == s.len() - 1));
   endtask

   task automatic idle();
      bit acc;
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, acc);
   endtask

   task automatic do_reset();
      bit acc;
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      logic [7:0] c;
      int r;
      m_valid = 1'b0;
      m_start = 0;
      m_len   = 0;
      m_cnt   = 0;
      rst_n = 1'b0; in_valid_i = 1'b0; in_char_i = 8'h00; in_last_i = 1'b0; out_ready_i = 1'b0;

      do_reset();
      do_reset();
      chk("rst_out_valid", out_valid_o, 0);
      chk("rst_out_start", out_start_o, 0);
      chk("rst_out_len", out_len_o, 0);
      chk("rst_match_cnt", match_cnt_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_in_ready", in_ready_o, 1);

      // "ab12 " with in_last on the space, then a fresh stream starts at 0
      send_str("ab12 ", 1'b1);
      chk("ab12_valid", out_valid_o, 1);
      chk("ab12_start", out_start_o, 0);
      chk("ab12_len", out_len_o, 4);
      chk("ab12_cnt", match_cnt_o, 1);
      idle();
      send_str("c5.", 1'b0);
      chk("pos0_start", out_start_o, 0);
      chk("pos0_len", out_len_o, 2);
      idle();

      do_reset();
      send_str("1a2;", 1'b0);
      chk("1a2_start", out_start_o, 1);
      chk("1a2_len", out_len_o, 2);
      idle();
      send_str("abc;", 1'b0);
      idle();
      chk("abc_norec_valid", out_valid_o, 0);
      chk("abc_norec_cnt", match_cnt_o, 1);

      do_reset();
      send_str("x9", 1'b1);
      chk("x9_start", out_start_o, 0);
      chk("x9_len", out_len_o, 2);
      idle();
      send_str("q7,", 1'b0);
      chk("q7_start", out_start_o, 0);
      chk("q7_len", out_len_o, 2);
      chk("q7_cnt", match_cnt_o, 2);
      idle();

      // Backpressure: hold the first record for 5 cycles with 'b' waiting
      do_reset();
      send_str("a1,", 1'b0);
      for (int k = 0; k < 5; k++) begin
         cycle(1'b1, "b", 1'b0, 1'b0, 1'b1, acc);
         chk("bp_accept", acc, 0);
         chk("bp_in_ready", in_ready_o, 0);
         chk("bp_hold_valid", out_valid_o, 1);
         chk("bp_hold_start", out_start_o, 0);
         chk("bp_hold_len", out_len_o, 2);
      end
      send_str("b2,", 1'b0);
      chk("bp_rec2_start", out_start_o, 3);
      chk("bp_rec2_len", out_len_o, 2);
      chk("bp_cnt", match_cnt_o, 2);
      idle();

      do_reset();
      send_char("a", 1'b0);
      for (int k = 0; k < 20; k++) send_char("5", 1'b0);
      send_char(",", 1'b0);
      chk("sat_start", out_start_o, 0);
      chk("sat_len", out_len_o, 15);
      idle();

      // Reset mid-segment with a handshake presented during reset
      do_reset();
      send_str("ab1", 1'b0);
      cycle(1'b1, "z", 1'b0, 1'b1, 1'b0, acc);
      chk("midrst_valid", out_valid_o, 0);
      send_str("c2.", 1'b0);
      chk("midrst_start", out_start_o, 0);
      chk("midrst_len", out_len_o, 2);
      chk("midrst_cnt", match_cnt_o, 1);
      idle();

      do_reset();
      send_str("_x3;", 1'b0);
      chk("us_start", out_start_o, US_EN ? 0 : 1);
      chk("us_len", out_len_o, US_EN ? 3 : 2);
      idle();

      do_reset();
      for (int n = 0; n < 4000; n++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1:    c = 8'h61 + 8'($urandom_range(0, 25));
            2:       c = 8'h41 + 8'($urandom_range(0, 25));
            3, 4, 5: c = 8'h30 + 8'($urandom_range(0, 9));
            6:       c = 8'h5F;
            7:       c = 8'h20;
            default: c = 8'($urandom_range(0, 255));
         endcase
         cycle(($urandom_range(0, 3) != 0), c, ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 199) != 0), acc);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
